control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: OPCODE_W, default 3, opcode width taken from ir[7:5].
REQ-002 Parameter: ADDR_W, default 5, operand/PC width taken from ir[4:0]; matches 5-bit PC register.
REQ-003 Port: clock  input  1  single rising-edge clock.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on clock rising edge only.
REQ-005 Port: start  input  1  begins execution from IDLE.
REQ-006 Port: ir  input  8  current IR register output; opcode = ir[7:5], operand = ir[4:0].
REQ-007 Port: acc_zero  input  1  accumulator-equals-zero flag.
REQ-008 Port: ir_load  output  1  load strobe to 8-bit IR register.
REQ-009 Port: pc_load  output  1  load strobe to 5-bit PC register.
REQ-010 Port: pc_sel  output  1  PC_D mux: 0 = PC+1, 1 = ir[4:0].
REQ-011 Port: addr_sel  output  1  memory address mux: 0 = PC, 1 = ir[4:0].
REQ-012 Port: acc_load  output  1  accumulator load strobe.
REQ-013 Port: alu_op  output  2  00 PASS, 01 ADD, 10 SUB, 11 unused.
REQ-014 Port: mem_we  output  1  data memory write strobe.
REQ-015 Port: halted  output  1  high while in HALT state.
REQ-016 Port: state  output  3  current state encoding, for debug.
REQ-017 Port: instr_count  output  8  count of completed instructions.

Function
REQ-018 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5; codes 6-7 SHALL go to IDLE on next edge.
REQ-019 IDLE: all strobes 0; start=1 -> FETCH, else stay.
REQ-020 FETCH: ir_load=1, addr_sel=0; -> DECODE.
REQ-021 DECODE: pc_load=1, pc_sel=0 (PC+1); -> EXEC.
REQ-022 EXEC opcode 000 HALT: no strobes; -> HALT.
REQ-023 EXEC 001 LOAD, 011 ADD, 100 SUB: addr_sel=1; -> MEM.
REQ-024 MEM: addr_sel=1, acc_load=1, alu_op = 00/01/10 for LOAD/ADD/SUB; instruction completes.
REQ-025 EXEC 010 STORE: addr_sel=1, mem_we=1 for exactly one cycle; completes.
REQ-026 EXEC 101 JMP: pc_load=1, pc_sel=1; completes.
REQ-027 EXEC 110 JZ: if acc_zero=1 then pc_load=1, pc_sel=1, else no strobes; completes.
REQ-028 EXEC 111 NOP: no strobes; completes.
REQ-029 On completion (end of EXEC or MEM), next state SHALL be FETCH, except as modified by REQ-036.
REQ-030 ir SHALL be decoded only in EXEC/MEM; ir changes in other states SHALL be ignored.
REQ-031 instr_count SHALL increment by 1 on each completing edge, including HALT entry; 255 wraps to 0.
REQ-032 HALT: halted=1, all strobes 0, state held; start ignored; exit only via reset.
REQ-033 All strobe outputs SHALL be combinational from state and ir, glitch-free relative to clock edge; at most one of ir_load/pc_load per cycle.
REQ-034 Latency: LOAD/ADD/SUB 4 cycles FETCH-to-FETCH; all others 3 cycles.

Reset
REQ-035 reset=0 at a rising edge SHALL force state=IDLE, instr_count=0, halted=0, all strobes 0 from the following cycle, in any state including mid-instruction; start is ignored in that cycle.

Configuration
REQ-036 Macro STEP_MODE_EN: when defined, each completing instruction SHALL return to IDLE (one start pulse per instruction); when undefined, completion SHALL go directly to FETCH and start is sampled only in IDLE.

Verification
REQ-037 reset=0 for 2 edges, then reset=1, start=0 -> state=0, instr_count=0, all strobes 0 for 5 cycles.
REQ-038 start=1 one cycle, ir=8'b001_00011 -> ir_load in cycle 1, pc_load/pc_sel=0 in cycle 2, addr_sel=1 cycle 3, acc_load=1 alu_op=00 cycle 4, instr_count=1, state=FETCH.
REQ-039 ir=8'b110_10100, acc_zero=1 -> pc_load=1, pc_sel=1 in EXEC; repeat with acc_zero=0 -> pc_load=0 in EXEC.
REQ-040 ir=8'b010_00111 -> mem_we high exactly one cycle with addr_sel=1; then ir=8'b000_00000 -> halted=1, start pulses ignored, instr_count=2.
REQ-041 reset=0 asserted during MEM of ADD -> acc_load not asserted next cycle, state=IDLE, instr_count=0.
REQ-042 NOP stream for 256 instructions -> instr_count wraps to 0; with STEP_MODE_EN, state=IDLE after each NOP until start.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for an accumulator CPU: FETCH/DECODE/EXEC/MEM/HALT.
// Optional macro STEP_MODE_EN: each completed instruction parks in IDLE awaiting start.
module control_sequencer #(
    parameter int OPCODE_W = 3,
    parameter int ADDR_W   = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [OPCODE_W+ADDR_W-1:0] ir,
    input  logic                       acc_zero,
    output logic                       ir_load,
    output logic                       pc_load,
    output logic                       pc_sel,
    output logic                       addr_sel,
    output logic                       acc_load,
    output logic [1:0]                 alu_op,
    output logic                       mem_we,
    output logic                       halted,
    output logic [2:0]                 state,
    output logic [7:0]                 instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

`ifdef STEP_MODE_EN
    localparam logic [2:0] S_DONE = S_IDLE;
`else
    localparam logic [2:0] S_DONE = S_FETCH;
`endif

    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JZ    = OPCODE_W'(6);

    logic [OPCODE_W-1:0] opcode;
    logic                mem_op;
    logic [2:0]          next_state;
    logic                done;

    // Only the opcode field steers control; the operand goes straight to the datapath muxes.
    assign opcode = ir[ADDR_W +: OPCODE_W];
    assign mem_op = (opcode == OP_LOAD) || (opcode == OP_ADD) || (opcode == OP_SUB);
    assign halted = (state == S_HALT);

    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            S_IDLE:   if (start) next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_HALT) begin
                    next_state = S_HALT;
                    done       = 1'b1;
                end else if (mem_op) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_DONE;
                    done       = 1'b1;
                end
            end
            S_MEM: begin
                next_state = S_DONE;
                done       = 1'b1;
            end
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ir_load  = 1'b0;
        pc_load  = 1'b0;
        pc_sel   = 1'b0;
        addr_sel = 1'b0;
        acc_load = 1'b0;
        alu_op   = 2'b00;
        mem_we   = 1'b0;
        case (state)
            S_FETCH:  ir_load = 1'b1;
            S_DECODE: pc_load = 1'b1;
            S_EXEC: begin
                if (mem_op) addr_sel = 1'b1;
                if (opcode == OP_STORE) begin
                    addr_sel = 1'b1;
                    mem_we   = 1'b1;
                end
                if ((opcode == OP_JMP) || ((opcode == OP_JZ) && acc_zero)) begin
                    pc_load = 1'b1;
                    pc_sel  = 1'b1;
                end
            end
            S_MEM: begin
                addr_sel = 1'b1;
                acc_load = 1'b1;
                if (opcode == OP_ADD)      alu_op = 2'b01;
                else if (opcode == OP_SUB) alu_op = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            instr_count <= 8'd0;
        end else begin
            state <= next_state;
            if (done) instr_count <= instr_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; honours STEP_MODE_EN when defined.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] ir = 8'h00;
    logic       acc_zero = 1'b0;
    logic       ir_load, pc_load, pc_sel, addr_sel, acc_load, mem_we, halted;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic [7:0] instr_count;
    logic [7:0] strb;

    int total = 0;
    int bad   = 0;

`ifdef STEP_MODE_EN
    localparam logic [2:0] S_DONE = 3'd0;
`else
    localparam logic [2:0] S_DONE = 3'd1;
`endif

    // strobe bundle: ir_load, pc_load, pc_sel, addr_sel, acc_load, alu_op[1:0], mem_we
    assign strb = {ir_load, pc_load, pc_sel, addr_sel, acc_load, alu_op, mem_we};

    control_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .ir(ir), .acc_zero(acc_zero),
        .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel), .addr_sel(addr_sel),
        .acc_load(acc_load), .alu_op(alu_op), .mem_we(mem_we), .halted(halted),
        .state(state), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // In step mode a finished instruction waits in IDLE for a start pulse.
    task automatic resume;
`ifdef STEP_MODE_EN
        start = 1'b1;
        tick();
        start = 1'b0;
`endif
    endtask

    task automatic test_reset;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({state, instr_count, strb, halted} !== {3'd0, 8'd0, 8'h00, 1'b0}) begin
                bad++;
                $display("FAIL reset_idle cyc%0d: state=%0d cnt=%0d strb=%h halted=%b want 0/0/00/0",
                         i, state, instr_count, strb, halted);
            end
        end
    endtask

    task automatic test_mem_ops;
        logic [7:0] ops  [3] = '{8'b001_00011, 8'b011_00001, 8'b100_00010};
        logic [7:0] mstb [3] = '{8'h18, 8'h1A, 8'h1C};
        do_reset();
        ir    = ops[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ir = ops[k];
            total++;
            if (state !== 3'd1 || strb !== 8'h80) begin
                bad++;
                $display("FAIL memop%0d_fetch: state=%0d strb=%h want 1/80", k, state, strb);
            end
            tick();
            total++;
            if (state !== 3'd2 || strb !== 8'h40) begin
                bad++;
                $display("FAIL memop%0d_decode: state=%0d strb=%h want 2/40", k, state, strb);
            end
            tick();
            total++;
            if (state !== 3'd3 || strb !== 8'h10) begin
                bad++;
                $display("FAIL memop%0d_exec: state=%0d strb=%h want 3/10", k, state, strb);
            end
            tick();
            total++;
            if (state !== 3'd4 || strb !== mstb[k] || instr_count !== 8'(k)) begin
                bad++;
                $display("FAIL memop%0d_mem: state=%0d strb=%h cnt=%0d want 4/%h/%0d",
                         k, state, strb, instr_count, mstb[k], k);
            end
            tick();
            total++;
            if (state !== S_DONE || instr_count !== 8'(k + 1)) begin
                bad++;
                $display("FAIL memop%0d_done: state=%0d cnt=%0d want %0d/%0d",
                         k, state, instr_count, S_DONE, k + 1);
            end
            resume();
        end
    endtask

    task automatic test_branches;
        do_reset();
        ir       = 8'b110_10100;
        acc_zero = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total++;
        if (state !== 3'd3 || strb !== 8'h60) begin
            bad++;
            $display("FAIL jz_taken: state=%0d strb=%h want 3/60", state, strb);
        end
        tick();
        resume();
        acc_zero = 1'b0;
        tick();
        tick();
        total++;
        if (state !== 3'd3 || strb !== 8'h00) begin
            bad++;
            $display("FAIL jz_not_taken: state=%0d strb=%h want 3/00", state, strb);
        end
        tick();
        resume();
        ir = 8'b101_01010;
        tick();
        tick();
        total++;
        if (state !== 3'd3 || strb !== 8'h60) begin
            bad++;
            $display("FAIL jmp: state=%0d strb=%h want 3/60", state, strb);
        end
        tick();
        total++;
        if (state !== S_DONE || instr_count !== 8'd3) begin
            bad++;
            $display("FAIL branch_count: state=%0d cnt=%0d want %0d/3", state, instr_count, S_DONE);
        end
    endtask

    task automatic test_store_halt;
        do_reset();
        ir    = 8'b010_00111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total++;
        if (state !== 3'd3 || strb !== 8'h11) begin
            bad++;
            $display("FAIL store_exec: state=%0d strb=%h want 3/11", state, strb);
        end
        tick();
        total++;
        if (mem_we !== 1'b0 || instr_count !== 8'd1) begin
            bad++;
            $display("FAIL store_one_cycle: mem_we=%b cnt=%0d want 0/1", mem_we, instr_count);
        end
        resume();
        ir = 8'b000_00000;
        tick();
        tick();
        total++;
        if (state !== 3'd3 || strb !== 8'h00 || halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_exec: state=%0d strb=%h halted=%b want 3/00/0", state, strb, halted);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            start = i[0];
            total++;
            if (state !== 3'd5 || halted !== 1'b1 || strb !== 8'h00 || instr_count !== 8'd2) begin
                bad++;
                $display("FAIL halt_hold%0d: state=%0d halted=%b strb=%h cnt=%0d want 5/1/00/2",
                         i, state, halted, strb, instr_count);
            end
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++;
        if (state !== 3'd0 || halted !== 1'b0 || instr_count !== 8'd0) begin
            bad++;
            $display("FAIL halt_exit_reset: state=%0d halted=%b cnt=%0d want 0/0/0",
                     state, halted, instr_count);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        ir    = 8'b111_00000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        resume();
        ir = 8'b011_00100;
        tick();
        tick();
        tick();
        total++;
        if (state !== 3'd4 || strb !== 8'h1A || instr_count !== 8'd1) begin
            bad++;
            $display("FAIL add_mem: state=%0d strb=%h cnt=%0d want 4/1A/1", state, strb, instr_count);
        end
        reset = 1'b0;
        start = 1'b1;
        tick();
        total++;
        if (state !== 3'd0 || acc_load !== 1'b0 || strb !== 8'h00 || instr_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid_mem: state=%0d acc_load=%b strb=%h cnt=%0d want 0/0/00/0",
                     state, acc_load, strb, instr_count);
        end
        reset = 1'b1;
        start = 1'b0;
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL start_ignored_in_reset: state=%0d want 0", state);
        end
    endtask

    task automatic test_nop_wrap;
        int idle_bad = 0;
        do_reset();
        ir    = 8'b111_11111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            tick();
            tick();
            if (state !== S_DONE) idle_bad++;
            if (i == 1) begin
                total++;
                if (instr_count !== 8'd1) begin
                    bad++;
                    $display("FAIL nop_first: cnt=%0d want 1", instr_count);
                end
            end
            if (i == 255) begin
                total++;
                if (instr_count !== 8'd255) begin
                    bad++;
                    $display("FAIL nop_255: cnt=%0d want 255", instr_count);
                end
            end
            resume();
        end
        total++;
        if (instr_count !== 8'd0) begin
            bad++;
            $display("FAIL nop_wrap: cnt=%0d want 0", instr_count);
        end
        total++;
        if (idle_bad != 0) begin
            bad++;
            $display("FAIL nop_done_state: %0d completions not in state %0d", idle_bad, S_DONE);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mem_ops();
        test_branches();
        test_store_halt();
        test_reset_mid();
        test_nop_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
